// File: rtl/gf_inv8_seq_if.sv
`default_nettype none
// ============================================================================
// gf_inv8_seq_if : valid/ready byte streams in and out of the GF(2^8) inverter
// Revision 1.0
// ============================================================================
interface gf_inv8_seq_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       busy;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, busy
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, busy
  );
endinterface
`default_nettype wire

// File: rtl/gf_inv8_seq.sv
`default_nettype none
// ============================================================================
// gf_inv8_seq : iterative GF(2^8) inverter, a -> a^254 using one square+multiply unit
// Revision 1.0
// ============================================================================
module gf_inv8_seq #(
  parameter logic [7:0] POLY = 8'h1B
) (
  input  wire logic       clk,
  input  wire logic       rst_n,
  gf_inv8_seq_if.slave    bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [2:0] LAST_STEP = 3'd6;

  state_t     state;
  state_t     state_nx;
  logic [7:0] a;
  logic [7:0] r;
  logic [7:0] result;
  logic [2:0] cnt;
  logic       load;
  logic       iterate;
  logic       finish;
  logic [7:0] r_sq;
  logic [7:0] r_step;

  // Fold bits 14..8 back into the low byte using x^8 = POLY, highest first.
  function automatic logic [7:0] gf_reduce(input logic [14:0] p);
    logic [14:0] v;
    logic [14:0] m;
    v = p;
    m = {6'b0, 1'b1, POLY};
    for (int i = 14; i >= 8; i--) begin
      if (v[i]) begin
        v = v ^ (m << (i - 8));
      end
    end
    return v[7:0];
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] y);
    logic [14:0] p;
    p = '0;
    for (int i = 0; i < 8; i++) begin
      if (y[i]) begin
        p = p ^ ({7'b0, x} << i);
      end
    end
    return gf_reduce(p);
  endfunction

  // Squaring in characteristic 2 just spreads the bits to even positions.
  function automatic logic [7:0] gf_sq(input logic [7:0] x);
    logic [14:0] p;
    p = '0;
    for (int i = 0; i < 8; i++) begin
      p[2*i] = x[i];
    end
    return gf_reduce(p);
  endfunction

  assign r_sq   = gf_sq(r);
  assign r_step = gf_mul(r_sq, a);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    load     = 1'b0;
    iterate  = 1'b0;
    finish   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.in_valid) begin
          load     = 1'b1;
          state_nx = CALC;
        end
      end
      CALC: begin
        if (cnt == LAST_STEP) begin
          finish   = 1'b1;
          state_nx = DONE;
        end else begin
          iterate = 1'b1;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // r walks a, a^3, a^7, ..., a^127; the final square gives a^254.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a      <= 8'h00;
      r      <= 8'h00;
      cnt    <= 3'd0;
      result <= 8'h00;
    end else begin
      if (load) begin
        a   <= bus.in_data;
        r   <= bus.in_data;
        cnt <= 3'd0;
      end else if (iterate) begin
        r   <= r_step;
        cnt <= cnt + 3'd1;
      end
      if (finish) begin
        result <= r_sq;
      end
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.busy      = (state != IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.out_data  = result;

endmodule
`default_nettype wire

// File: tb/tb_gf_inv8_seq.sv
`default_nettype none
// ============================================================================
// tb_gf_inv8_seq : scoreboard bench for the iterative GF(2^8) inverter
// Revision 1.0
// ============================================================================
module tb_gf_inv8_seq;

  typedef struct {
    logic [7:0] a;
    logic [7:0] exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  gf_inv8_seq_if bus ();

  gf_inv8_seq #(.POLY(8'h1B)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  vec_t       sb_q[$];
  vec_t       table_v[5];
  logic [7:0] ref_tab[256];
  int         checks   = 0;
  int         failures = 0;
  int         cyc      = 0;
  int         acc_cyc  = 0;
  bit         inflight = 1'b0;
  bit         accepted = 1'b0;
  bit         prod_chk = 1'b0;
  logic [7:0] drive_exp = 8'h00;
  logic [7:0] last_out  = 8'h00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Shift-and-xtime multiplier in the AES field.
  function automatic logic [7:0] gf_mul_ref(input logic [7:0] x_in, input logic [7:0] y_in);
    logic [7:0] x;
    logic [7:0] y;
    logic [7:0] p;
    logic       hi;
    x = x_in;
    y = y_in;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      hi = x[7];
      x  = {x[6:0], 1'b0};
      if (hi) x = x ^ 8'h1B;
      y = {1'b0, y[7:1]};
    end
    return p;
  endfunction

  // Called at a falling edge with inputs already driven; checks state, then advances one cycle.
  task automatic tick();
    vec_t v;
    bit   out_v_exp;
    bit   take;
    out_v_exp = inflight && ((cyc - acc_cyc) >= 8);
    chk("busy", {31'b0, bus.busy}, {31'b0, inflight});
    chk("in_ready", {31'b0, bus.in_ready}, {31'b0, !inflight});
    chk("out_valid", {31'b0, bus.out_valid}, {31'b0, out_v_exp});
    if (!inflight) chk("out_data_hold", {24'b0, bus.out_data}, {24'b0, last_out});
    take     = out_v_exp && bus.out_ready;
    accepted = bus.in_valid && !inflight;
    if (take) begin
      if (sb_q.size() == 0) begin
        chk("sb_underflow", 32'd1, 32'd0);
      end else begin
        v = sb_q.pop_front();
        chk("result", {24'b0, bus.out_data}, {24'b0, v.exp});
        if (prod_chk)
          chk("a_times_inv", {24'b0, gf_mul_ref(v.a, bus.out_data)},
              (v.a == 8'h00) ? 32'd0 : 32'd1);
        last_out = v.exp;
      end
      inflight = 1'b0;
    end
    if (accepted) begin
      sb_q.push_back('{a: bus.in_data, exp: drive_exp});
      inflight = 1'b1;
      acc_cyc  = cyc;
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic wait_accept();
    bit got;
    got = 1'b0;
    for (int k = 0; k < 30 && !got; k++) begin
      tick();
      got = accepted;
    end
    if (!got) chk("accept_timeout", 32'd0, 32'd1);
    bus.in_valid = 1'b0;
  endtask

  task automatic drain(input bit scramble);
    int k;
    k = 0;
    while ((inflight || sb_q.size() != 0) && k < 40) begin
      if (scramble) bus.in_data = 8'($urandom);
      tick();
      k++;
    end
    if (k >= 40) chk("drain_timeout", 32'd0, 32'd1);
  endtask

  task automatic run_op(input logic [7:0] a, input logic [7:0] exp);
    bus.in_valid = 1'b1;
    bus.in_data  = a;
    drive_exp    = exp;
    wait_accept();
    drain(1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] b2b_data[6];
    int         n_acc;
    int         prev_acc;

    table_v[0] = '{a: 8'h00, exp: 8'h00};
    table_v[1] = '{a: 8'h01, exp: 8'h01};
    table_v[2] = '{a: 8'h02, exp: 8'h8D};
    table_v[3] = '{a: 8'hFF, exp: 8'h1C};
    table_v[4] = '{a: 8'h53, exp: 8'hCA};
    b2b_data   = '{8'h53, 8'h02, 8'hFF, 8'h01, 8'h00, 8'h10};

    ref_tab[0] = 8'h00;
    for (int x = 1; x < 256; x++) begin
      ref_tab[x] = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gf_mul_ref(8'(x), 8'(y)) == 8'h01) ref_tab[x] = 8'(y);
    end

    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = 8'h00;
    bus.out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rst_in_ready", {31'b0, bus.in_ready}, 32'd1);
    chk("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("rst_busy", {31'b0, bus.busy}, 32'd0);
    chk("rst_out_data", {24'b0, bus.out_data}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 5; i++) run_op(table_v[i].a, table_v[i].exp);

    // Abort mid-calculation: reset must clear outputs without waiting for a clock.
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h53;
    drive_exp    = 8'hCA;
    wait_accept();
    for (int i = 0; i < 3; i++) tick();
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("async_rst_in_ready", {31'b0, bus.in_ready}, 32'd1);
    chk("async_rst_busy", {31'b0, bus.busy}, 32'd0);
    chk("async_rst_out_data", {24'b0, bus.out_data}, 32'd0);
    sb_q.delete();
    inflight = 1'b0;
    last_out = 8'h00;
    @(negedge clk);
    cyc++;
    rst_n = 1'b1;
    for (int i = 0; i < 15; i++) tick();

    // Backpressure: result must hold and no new operand may slip in.
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h53;
    drive_exp    = 8'hCA;
    wait_accept();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h10;
    drive_exp    = 8'hFF;
    for (int i = 0; i < 20; i++) begin
      chk("stall_out_data", {24'b0, bus.out_data}, 32'hCA);
      tick();
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    drain(1'b0);

    // Back-to-back with continuous valid: one accept every 9 cycles.
    bus.in_valid = 1'b1;
    n_acc    = 0;
    prev_acc = 0;
    bus.in_data = b2b_data[0];
    drive_exp   = ref_tab[b2b_data[0]];
    for (int k = 0; k < 80 && n_acc < 6; k++) begin
      tick();
      if (accepted) begin
        if (n_acc > 0) chk("initiation_interval", 32'(acc_cyc - prev_acc), 32'd9);
        prev_acc = acc_cyc;
        n_acc++;
        if (n_acc < 6) begin
          bus.in_data = b2b_data[n_acc];
          drive_exp   = ref_tab[b2b_data[n_acc]];
        end
      end
    end
    chk("b2b_accepts", 32'(n_acc), 32'd6);
    bus.in_valid = 1'b0;
    drain(1'b0);

    // Operand must be latched at accept; later input activity is ignored.
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h02;
    drive_exp    = 8'h8D;
    wait_accept();
    drain(1'b1);

    prod_chk = 1'b1;
    for (int x = 0; x < 256; x++) run_op(8'(x), ref_tab[x]);
    prod_chk = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
